// File: rtl/reg_file.sv
// reg_file: RV32 integer register file, x0..x31, two combinational read
// ports with write-through bypass and one synchronous write port.
// x0 always reads as zero and ignores writes. rst_n clears storage
// asynchronously, blocks writes and forces both read ports to zero.
module reg_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    // Storage. Entry 0 is reset to zero and never written, so it is constant.
    logic [DATA_WIDTH-1:0] regs_reg [NUM_REGS];

    // One-hot write select per register; bit 0 is permanently off.
    logic [NUM_REGS-1:0] wr_sel;

    // Write is live only outside reset and never for x0.
    logic wr_live;
    assign wr_live = rst_n && we && (rd_addr != '0);

    assign wr_sel[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_live && (rd_addr == ADDR_WIDTH'(gi));
        end
    endgenerate

    // Register array update: async clear, one-edge write latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wr_sel[i]) begin
                    regs_reg[i] <= rd_data;
                end
            end
        end
    end

    // Read port 1: zero for x0 or in reset, bypass on a matching write.
    always_comb begin
        rs1_data = '0;
        if (rst_n && (rs1_addr != '0)) begin
            if (wr_live && (rd_addr == rs1_addr)) begin
                rs1_data = rd_data;
            end else begin
                rs1_data = regs_reg[rs1_addr];
            end
        end
    end

    // Read port 2: same rules as port 1, evaluated independently.
    always_comb begin
        rs2_data = '0;
        if (rst_n && (rs2_addr != '0)) begin
            if (wr_live && (rd_addr == rs2_addr)) begin
                rs2_data = rd_data;
            end else begin
                rs2_data = regs_reg[rs2_addr];
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: self-checking bench for reg_file against an array model.
`timescale 1ns/1ps
module tb_reg_file;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    int checks = 0;
    int fails  = 0;

    // Reference: what each architectural register holds.
    logic [31:0] model [32];

    reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value architecturally visible on a read port this cycle.
    function automatic logic [31:0] expect_read(input logic [4:0] a);
        if (!rst_n || a == 5'd0) return 32'h0;
        if (we && rd_addr != 5'd0 && rd_addr == a) return rd_data;
        return model[a];
    endfunction

    // Commit the currently driven write through one rising edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n && we && rd_addr != 5'd0) model[rd_addr] = rd_data;
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; rd_addr = a; rd_data = d;
        tick();
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; we = 1'b0; rd_addr = 0; rd_data = 0;
        rs1_addr = 5'd3; rs2_addr = 5'd31;
        #12;
        checks++;
        if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_outputs rs1=%h rs2=%h required 0/0", rs1_data, rs2_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        tick();
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i); #1;
            checks++;
            if (rs1_data !== 32'h0) begin
                fails++;
                $display("FAIL reset_reg x%0d got %h required 0", i, rs1_data);
            end
        end
        $display("reset: all registers read zero after release");
    endtask

    task automatic test_basic();
        write_reg(5'd1, 32'hA5A5A5A5);
        rs1_addr = 5'd1; rs2_addr = 5'd0; #1;
        checks++;
        if (rs1_data !== 32'hA5A5A5A5 || rs2_data !== 32'h0) begin
            fails++;
            $display("FAIL basic_rw rs1=%h rs2=%h required a5a5a5a5/0", rs1_data, rs2_data);
        end
        $display("basic: x1 <= a5a5a5a5, read rs1=%h rs2=%h", rs1_data, rs2_data);
    endtask

    task automatic test_x0();
        @(negedge clk);
        we = 1'b1; rd_addr = 5'd0; rd_data = 32'hFFFFFFFF; rs1_addr = 5'd0; rs2_addr = 5'd0; #1;
        checks++;
        if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
            fails++;
            $display("FAIL x0_no_bypass rs1=%h rs2=%h required 0/0", rs1_data, rs2_data);
        end
        tick();
        @(negedge clk);
        we = 1'b0; #1;
        checks++;
        if (rs1_data !== 32'h0) begin
            fails++;
            $display("FAIL x0_write_discarded got %h required 0", rs1_data);
        end
        $display("x0: write of ffffffff discarded, read %h", rs1_data);
    endtask

    task automatic test_write_disable();
        write_reg(5'd5, 32'h12345678);
        @(negedge clk);
        we = 1'b0; rd_addr = 5'd5; rd_data = 32'hDEADBEEF;
        repeat (4) tick();
        rs1_addr = 5'd5; rs2_addr = 5'd5; #1;
        checks++;
        if (rs1_data !== 32'h12345678 || rs2_data !== 32'h12345678) begin
            fails++;
            $display("FAIL write_disable rs1=%h rs2=%h required 12345678", rs1_data, rs2_data);
        end
        $display("write_disable: x5 reads %h", rs1_data);
    endtask

    task automatic test_bypass();
        write_reg(5'd7, 32'h11111111);
        @(negedge clk);
        rs1_addr = 5'd7; rs2_addr = 5'd7; #1;
        checks++;
        if (rs1_data !== 32'h11111111) begin
            fails++;
            $display("FAIL bypass_old got %h required 11111111", rs1_data);
        end
        we = 1'b1; rd_addr = 5'd7; rd_data = 32'h22222222; #1;
        checks++;
        if (rs1_data !== 32'h22222222 || rs2_data !== 32'h22222222) begin
            fails++;
            $display("FAIL bypass_pre_edge rs1=%h rs2=%h required 22222222", rs1_data, rs2_data);
        end
        tick();
        @(negedge clk);
        we = 1'b0; #1;
        checks++;
        if (rs1_data !== 32'h22222222 || rs2_data !== 32'h22222222) begin
            fails++;
            $display("FAIL bypass_post_edge rs1=%h rs2=%h required 22222222", rs1_data, rs2_data);
        end
        $display("bypass: x7 11111111 -> 22222222 seen on both ports");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        we = 1'b1; rd_addr = 5'd9; rd_data = 32'hAAAA0001;
        tick();
        rd_data = 32'hAAAA0002;
        tick();
        @(negedge clk);
        we = 1'b0; rs1_addr = 5'd9; #1;
        checks++;
        if (rs1_data !== 32'hAAAA0002) begin
            fails++;
            $display("FAIL back_to_back got %h required aaaa0002", rs1_data);
        end
        $display("back_to_back: x9 reads %h", rs1_data);
    endtask

    task automatic test_sweep();
        for (int i = 1; i < 32; i++) write_reg(5'(i), (32'(i) << 24) | 32'(i));
        for (int i = 0; i < 32; i++) begin
            logic [31:0] e1, e2;
            rs1_addr = 5'(i); rs2_addr = 5'(31 - i); #1;
            e1 = (i == 0) ? 32'h0 : ((32'(i) << 24) | 32'(i));
            e2 = (i == 31) ? 32'h0 : ((32'(31 - i) << 24) | 32'(31 - i));
            checks++;
            if (rs1_data !== e1 || rs2_data !== e2) begin
                fails++;
                $display("FAIL sweep pair (%0d,%0d) got %h/%h required %h/%h",
                         i, 31 - i, rs1_data, rs2_data, e1, e2);
            end
        end
        $display("sweep: 32 read pairs checked");
    endtask

    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            we       = ($urandom_range(0, 3) != 0);
            rd_addr  = 5'($urandom_range(0, 31));
            rd_data  = $urandom;
            rs1_addr = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom_range(0, 31));
            rs2_addr = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom_range(0, 31));
            #1;
            checks++;
            if (rs1_data !== expect_read(rs1_addr) || rs2_data !== expect_read(rs2_addr)) begin
                fails++;
                $display("FAIL random n=%0d rs1[%0d]=%h rs2[%0d]=%h required %h/%h", n,
                         rs1_addr, rs1_data, rs2_addr, rs2_data,
                         expect_read(rs1_addr), expect_read(rs2_addr));
            end
            tick();
        end
        @(negedge clk);
        we = 1'b0;
        $display("random: 300 cycles compared against model");
    endtask

    task automatic test_async_reset();
        for (int i = 1; i < 32; i++) write_reg(5'(i), $urandom | 32'h1);
        rs1_addr = 5'd4; rs2_addr = 5'd17;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        #1;
        checks++;
        if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
            fails++;
            $display("FAIL async_reset_immediate rs1=%h rs2=%h required 0/0", rs1_data, rs2_data);
        end
        we = 1'b1; rd_addr = 5'd12; rd_data = 32'hCAFEF00D; rs1_addr = 5'd12; #1;
        checks++;
        if (rs1_data !== 32'h0) begin
            fails++;
            $display("FAIL reset_blocks_bypass got %h required 0", rs1_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        we = 1'b0; rst_n = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i); rs2_addr = 5'(31 - i); #1;
            checks++;
            if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
                fails++;
                $display("FAIL post_reset pair (%0d,%0d) got %h/%h required 0/0",
                         i, 31 - i, rs1_data, rs2_data);
            end
        end
        $display("async_reset: storage cleared, write during reset ignored");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_x0();
        test_write_disable();
        test_bypass();
        test_back_to_back();
        test_sweep();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Runaway guard: the sequence above is a few thousand cycles at most.
    initial begin
        #200000;
        $display("FAIL timeout bench did not complete within 200000 ns");
        $fatal(1, "timeout");
    end

endmodule
